// File: rtl/pipe_ctrl_stage.sv
// Pipeline stage register carrying a WIDTH-bit bundle over valid/ready, with flush-to-bubble,
// an optional one-entry skid buffer for a registered in_ready, and saturating stall/bubble counters.
module pipe_ctrl_stage #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      SKID   = 1,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             sk_valid_q, sk_valid_d;
  logic [WIDTH-1:0] sk_data_q, sk_data_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    sk_valid_d   = sk_valid_q;
    sk_data_d    = sk_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
      sk_valid_d   = 1'b0;
      sk_data_d    = BUBBLE;
    end else if (SKID != 0) begin
      if (sk_valid_q) begin
        // in_ready is low while skid is full, so only a drain can happen here
        if (drain) begin
          main_valid_d = 1'b1;
          main_data_d  = sk_data_q;
          sk_valid_d   = 1'b0;
          sk_data_d    = BUBBLE;
        end
      end else if (!main_valid_q || drain) begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else if (drain) begin
          main_valid_d = 1'b0;
          main_data_d  = BUBBLE;
        end
      end else if (accept) begin
        sk_valid_d = 1'b1;
        sk_data_d  = in_data;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (drain) begin
        main_valid_d = 1'b0;
        main_data_d  = BUBBLE;
      end
    end
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_ONE;
    if (!main_valid_q && (bubble_q != {CNT_W{1'b1}}))
      bubble_d = bubble_q + CNT_ONE;
  end

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE;
      sk_valid_q   <= 1'b0;
      sk_data_q    <= BUBBLE;
      stall_q      <= '0;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      sk_valid_q   <= sk_valid_d;
      sk_data_q    <= sk_data_d;
      stall_q      <= stall_d;
      bubble_q     <= bubble_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered copy of !sk_valid so in_ready leaves the stage straight from a flop
      logic in_ready_q;
      always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) in_ready_q <= 1'b1;
        else       in_ready_q <= ~sk_valid_d;
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = out_ready | ~main_valid_q;
    end
  endgenerate

  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage: three instances (skid, no-skid, 4-bit counters) on shared upstream
// inputs, checked against a FIFO-occupancy reference model plus a table of directed vectors.
module tb_pipe_ctrl_stage;

  localparam logic [15:0] BUB0 = 16'hF00D;
  localparam logic [15:0] BUB1 = 16'h0000;
  localparam logic [15:0] BUB2 = 16'h1234;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        u0_ir, u0_ov, u1_ir, u1_ov, u2_ir, u2_ov;
  logic [15:0] u0_od, u1_od, u2_od;
  logic [15:0] u0_sc, u0_bc, u1_sc, u1_bc;
  logic [3:0]  u2_sc, u2_bc;

  int tests = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl_stage #(.WIDTH(16), .BUBBLE(BUB0), .SKID(1), .CNT_W(16)) u0 (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(u0_ir),
    .flush(flush), .out_valid(u0_ov), .out_data(u0_od), .out_ready(out_ready),
    .stall_cnt(u0_sc), .bubble_cnt(u0_bc));

  pipe_ctrl_stage #(.WIDTH(16), .BUBBLE(BUB1), .SKID(0), .CNT_W(16)) u1 (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(u1_ir),
    .flush(flush), .out_valid(u1_ov), .out_data(u1_od), .out_ready(out_ready),
    .stall_cnt(u1_sc), .bubble_cnt(u1_bc));

  pipe_ctrl_stage #(.WIDTH(16), .BUBBLE(BUB2), .SKID(1), .CNT_W(4)) u2 (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(u2_ir),
    .flush(flush), .out_valid(u2_ov), .out_data(u2_od), .out_ready(out_ready),
    .stall_cnt(u2_sc), .bubble_cnt(u2_bc));

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid)
  int          m_cnt[3];
  logic [15:0] m_ent[3][2];
  int          m_st[3];
  int          m_bu[3];
  int          m_cap[3] = '{2, 1, 2};
  logic [15:0] m_bub[3] = '{BUB0, BUB1, BUB2};
  int          m_max[3] = '{65535, 65535, 15};

  function automatic logic m_ir(int i);
    if (m_cap[i] == 2) return (m_cnt[i] < 2);
    return (m_cnt[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_st[i] = 0; m_bu[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic d, a;
      a = in_valid && m_ir(i);
      d = (m_cnt[i] > 0) && out_ready;
      if (m_cnt[i] > 0 && !out_ready && m_st[i] < m_max[i]) m_st[i]++;
      if (m_cnt[i] == 0 && m_bu[i] < m_max[i]) m_bu[i]++;
      if (flush) m_cnt[i] = 0;
      else begin
        if (d) begin m_ent[i][0] = m_ent[i][1]; m_cnt[i]--; end
        if (a) begin m_ent[i][m_cnt[i]] = in_data; m_cnt[i]++; end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic ov, input logic [15:0] od, input logic ir,
                          input logic [31:0] sc, input logic [31:0] bc);
    chk($sformatf("u%0d.out_valid", i), {31'b0, ov}, {31'b0, m_cnt[i] > 0});
    chk($sformatf("u%0d.out_data", i), {16'b0, od}, {16'b0, (m_cnt[i] > 0) ? m_ent[i][0] : m_bub[i]});
    chk($sformatf("u%0d.in_ready", i), {31'b0, ir}, {31'b0, m_ir(i)});
    chk($sformatf("u%0d.stall_cnt", i), sc, m_st[i]);
    chk($sformatf("u%0d.bubble_cnt", i), bc, m_bu[i]);
  endtask

  task automatic model_check();
    chk_inst(0, u0_ov, u0_od, u0_ir, {16'b0, u0_sc}, {16'b0, u0_bc});
    chk_inst(1, u1_ov, u1_od, u1_ir, {16'b0, u1_sc}, {16'b0, u1_bc});
    chk_inst(2, u2_ov, u2_od, u2_ir, {28'b0, u2_sc}, {28'b0, u2_bc});
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic fl, input logic ordy);
    in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
  endtask

  // One falling edge: drive at rising edge, check combinational view, then advance the model
  task automatic step(input logic iv, input logic [15:0] d, input logic fl, input logic ordy);
    @(posedge CLK);
    drive(iv, d, fl, ordy);
    #1 model_check();
    $display("[TB] t=%0t iv=%0b d=%h fl=%0b ordy=%0b | u0 ov=%0b od=%h ir=%0b | u1 ov=%0b od=%h ir=%0b",
             $time, iv, d, fl, ordy, u0_ov, u0_od, u0_ir, u1_ov, u1_od, u1_ir);
    @(negedge CLK);
    model_step();
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic [15:0] ed;
    logic        eir;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    // Expected u0 state after each edge
    tbl[0]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1};
    tbl[1]  = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 16'h0022, 1'b1};
    tbl[2]  = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b1, 16'h0033, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, BUB0,     1'b1};
    tbl[4]  = '{1'b1, 16'h00AA, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b1};
    tbl[5]  = '{1'b1, 16'h00BB, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0};
    tbl[6]  = '{1'b1, 16'h00CC, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0};
    tbl[7]  = '{1'b1, 16'h00CC, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0};
    tbl[8]  = '{1'b1, 16'h00CC, 1'b0, 1'b1, 1'b1, 16'h00BB, 1'b1};
    tbl[9]  = '{1'b1, 16'h00CC, 1'b0, 1'b1, 1'b1, 16'h00CC, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, BUB0,     1'b1};
    tbl[11] = '{1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b1};
    tbl[12] = '{1'b1, 16'h0202, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
    tbl[13] = '{1'b1, 16'h0303, 1'b1, 1'b0, 1'b0, BUB0,     1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, BUB0,     1'b1};
    tbl[15] = '{1'b1, 16'h0404, 1'b0, 1'b1, 1'b1, 16'h0404, 1'b1};
    tbl[16] = '{1'b1, 16'h0505, 1'b1, 1'b1, 1'b0, BUB0,     1'b1};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, BUB0,     1'b1};

    model_reset();
    repeat (3) @(negedge CLK);
    #2 Reset = 1'b0;

    for (int k = 0; k < 5; k++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("idle.out_valid", {31'b0, u0_ov}, 32'd0);
    chk("idle.out_data", {16'b0, u0_od}, {16'b0, BUB0});
    chk("idle.in_ready", {31'b0, u0_ir}, 32'd1);
    chk("idle.stall_cnt", {16'b0, u0_sc}, 32'd0);
    chk("idle.bubble_cnt", {16'b0, u0_bc}, 32'd5);

    for (int k = 0; k < NV; k++) begin
      step(tbl[k].iv, tbl[k].d, tbl[k].fl, tbl[k].ordy);
      #1;
      chk($sformatf("vec%0d.out_valid", k), {31'b0, u0_ov}, {31'b0, tbl[k].ev});
      chk($sformatf("vec%0d.out_data", k), {16'b0, u0_od}, {16'b0, tbl[k].ed});
      chk($sformatf("vec%0d.in_ready", k), {31'b0, u0_ir}, {31'b0, tbl[k].eir});
      if (k == 10) begin
        chk("stall.stall_cnt", {16'b0, u0_sc}, 32'd3);
        chk("stall.bubble_cnt", {16'b0, u0_bc}, 32'd7);
      end
    end
    chk("flush.stall_cnt", {16'b0, u0_sc}, 32'd5);
    chk("flush.bubble_cnt", {16'b0, u0_bc}, 32'd11);

    // No-skid: in_ready follows out_ready combinationally, and a full stage reloads in one edge
    step(1'b1, 16'h0A01, 1'b0, 1'b0);
    @(posedge CLK);
    drive(1'b1, 16'h0A02, 1'b0, 1'b0);
    #1 chk("noskid.in_ready_stalled", {31'b0, u1_ir}, 32'd0);
    out_ready = 1'b1;
    #1 chk("noskid.in_ready_ready", {31'b0, u1_ir}, 32'd1);
    model_check();
    @(negedge CLK);
    model_step();
    #1;
    chk("noskid.replace.out_data", {16'b0, u1_od}, 32'h0A02);
    chk("noskid.replace.out_valid", {31'b0, u1_ov}, 32'd1);

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));

    // Asynchronous reset with main and skid both full
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0777, 1'b0, 1'b0);
    step(1'b1, 16'h0888, 1'b0, 1'b0);
    #1;
    chk("prereset.out_data", {16'b0, u0_od}, 32'h0777);
    chk("prereset.in_ready", {31'b0, u0_ir}, 32'd0);
    #1 Reset = 1'b1;
    #1;
    chk("areset.out_valid", {31'b0, u0_ov}, 32'd0);
    chk("areset.out_data", {16'b0, u0_od}, {16'b0, BUB0});
    chk("areset.in_ready", {31'b0, u0_ir}, 32'd1);
    chk("areset.stall_cnt", {16'b0, u0_sc}, 32'd0);
    chk("areset.bubble_cnt", {16'b0, u0_bc}, 32'd0);
    model_reset();
    #1 Reset = 1'b0;

    for (int k = 0; k < 20; k++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("sat.u2.bubble_cnt", {28'b0, u2_bc}, 32'd15);
    chk("sat.u0.bubble_cnt", {16'b0, u0_bc}, 32'd20);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk("sat.u2.bubble_held", {28'b0, u2_bc}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Parametrised pipeline stage register for the five-stage CPU. It carries a packed control/data bundle of configurable width between two stages using a valid/ready handshake. It supports downstream stall, synchronous flush that inserts a bubble, and an optional one-entry skid buffer that registers `in_ready`. It also provides saturating stall and bubble counters for performance inspection. It replaces per-stage fixed-field latches between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- `WIDTH`, default 16: width of the bundle carried through the stage.
- `BUBBLE`, default 0 (WIDTH bits): payload value presented when the stage is empty or flushed. It is a no-op control word.
- `SKID`, default 1: 1 selects the two-entry design with a registered `in_ready`; 0 selects a single entry with a combinational `in_ready`.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `CLK`, in, 1: clock. All state updates on the falling edge, per team pipeline convention.
- `Reset`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: upstream has a bundle.
- `in_data`, in, WIDTH: upstream bundle.
- `in_ready`, out, 1: stage accepts `in_data` at the next falling edge.
- `flush`, in, 1: discard all held and incoming bundles at the next falling edge.
- `out_valid`, out, 1: `out_data` holds a real bundle.
- `out_data`, out, WIDTH: bundle presented to the downstream stage. Equals `BUBBLE` when `out_valid` is 0.
- `out_ready`, in, 1: downstream consumes `out_data` at the next falling edge.
- `stall_cnt`, out, CNT_W: saturating count of stalled edges.
- `bubble_cnt`, out, CNT_W: saturating count of bubble edges.

## Operation
- Accept event A = `in_valid & in_ready`. Drain event D = `out_valid & out_ready`. Both events are evaluated at the falling edge.
- Main entry: (`out_valid`, `out_data`). Skid entry (SKID=1 only): (`sk_valid`, `sk_data`).
- SKID=1:
  - `in_ready` = `!sk_valid` and is driven only by a register.
  - Main empty or D, with skid empty: the accepted bundle goes to main.
  - Main full, no D, and A: the accepted bundle goes to skid.
  - D with skid full: skid moves to main and skid clears. A cannot occur in this case.
- SKID=0:
  - `in_ready` = `out_ready | !out_valid`, combinational.
  - On A, main loads `in_data`. Otherwise, on D, main empties.
- Main empties on D without a refill: `out_valid` goes to 0 and `out_data` goes to `BUBBLE`.
- Flush has priority over everything except Reset:
  - `out_valid` and `sk_valid` go to 0.
  - `out_data` and `sk_data` go to `BUBBLE`.
  - Any bundle accepted on the same edge is discarded.
  - Counters are unaffected, apart from the normal increment evaluated on that edge.
- Ordering is strictly FIFO. No bundle is duplicated or dropped except by flush.
- `stall_cnt` increments on each edge where `out_valid & !out_ready`.
- `bubble_cnt` increments on each edge where `!out_valid`. Both are values before the update.
- Both counters saturate at all-ones. Only Reset clears them.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = `BUBBLE`.
  - `sk_valid` = 0, `sk_data` = `BUBBLE`.
  - `in_ready` = 1.
  - `stall_cnt` = 0, `bubble_cnt` = 0.
- Reset asserted mid-transfer returns every output to its reset value immediately, without waiting for a clock edge. In-flight bundles are lost.
- Latency: a bundle accepted at falling edge N is on `out_data` with `out_valid` = 1 after edge N.
- Throughput: one bundle per edge while `out_ready` stays 1, in both SKID modes.
- SKID=1, stall behaviour:
  - After `out_ready` falls, at most one further bundle is accepted, into skid.
  - `in_ready` drops after that edge.
  - `in_ready` rises again on the edge where skid moves to main.
- Flush and `out_ready` together: the downstream consume at that edge is still counted as D. Next state is empty.
- Handshake rule: upstream holds `in_data` stable while `in_valid & !in_ready`. The stage does not require `in_valid` to stay asserted.

## Test plan
- Reset, then idle 5 edges:
  - Outputs: `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1, `stall_cnt` = 0.
  - `bubble_cnt` = 5.
- Streaming, SKID=1, `out_ready` = 1:
  - Drive 0x0011, 0x0022, 0x0033 on consecutive edges.
  - They appear in order, one edge later each. `in_ready` stays 1.
- Stall and skid:
  - Hold `out_ready` = 0 with main = 0x00AA and offer 0x00BB. 0x00BB goes to skid and `in_ready` = 0.
  - Offer 0x00CC. It is not accepted.
  - Raise `out_ready`. Outputs run 0x00AA, 0x00BB, 0x00CC with no loss.
  - `stall_cnt` equals the number of stalled edges.
- Flush with main and skid full and `in_valid` = 1:
  - Next edge: `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1.
  - The offered bundle is dropped.
- SKID=0: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 combinationally. With `out_ready` = 1, the new bundle replaces the old one on the same edge.
- Counter saturation, CNT_W=4: 20 idle edges give `bubble_cnt` = 15, held there.
